// File: rtl/aes_seq_ctrl_if.sv
// Word-stream and core-side signals of the AES block sequencer.
// slave = sequencer view, master = streamer/core/testbench view.
interface aes_seq_ctrl_if;
    logic [31:0]  in_data_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  out_data_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [255:0] core_key_o;
    logic         core_key_valid_o;
    logic [127:0] core_block_o;
    logic         core_start_o;
    logic         core_done_i;
    logic [127:0] core_result_i;

    // valid/ready: a word moves on every rising clk_i where valid and ready are both high;
    // the sender holds data stable while valid is high and ready is low.
    modport slave (
        input  in_data_i, in_valid_i, out_ready_i, core_done_i, core_result_i,
        output in_ready_o, out_data_o, out_valid_o,
               core_key_o, core_key_valid_o, core_block_o, core_start_o
    );

    modport master (
        output in_data_i, in_valid_i, out_ready_i, core_done_i, core_result_i,
        input  in_ready_o, out_data_o, out_valid_o,
               core_key_o, core_key_valid_o, core_block_o, core_start_o
    );
endinterface

// File: rtl/aes_seq_ctrl.sv
// AES block sequencer: packs key/input words for a 128-bit core and re-serialises results.
// Define AES_SEQ_CBC_EN to compile in CBC-encrypt chaining; otherwise ECB only.
module aes_seq_ctrl #(
    parameter int CNT_W        = 16,
    parameter int CORE_LAT_MAX = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] n_blocks_i,
    input  logic             key_len_i,
    input  logic [127:0]     iv_i,
    aes_seq_ctrl_if.slave    bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic [2:0]       state_dbg_o
);
    localparam int WD_W = $clog2(CORE_LAT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        EMIT  = 3'd5,
        DONE  = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [7:0][31:0]  key_q;
    logic [3:0][31:0]  blk_q;
    logic [3:0][31:0]  res_q;
    logic [2:0]        idx_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic [CNT_W-1:0]  n_blk_q;
    logic              key_len_q;
    logic              key_vld_q;
    logic              err_q;
    logic              hold_q;
    logic [WD_W-1:0]   wd_q;

    logic in_hs, out_hs, key_last, word_last, blk_last, wd_expired;

    assign in_hs      = bus.in_valid_i && bus.in_ready_o;
    assign out_hs     = bus.out_valid_o && bus.out_ready_i;
    assign key_last   = key_len_q ? (idx_q == 3'd7) : (idx_q == 3'd3);
    assign word_last  = (idx_q == 3'd3);
    assign blk_last   = ((blk_cnt_q + CNT_W'(1)) == n_blk_q);
    assign wd_expired = (wd_q == WD_W'(CORE_LAT_MAX - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_i) state_d = (n_blocks_i == '0) ? DONE : KEY;
            KEY:   if (in_hs && key_last) state_d = LOAD;
            LOAD:  if (in_hs && word_last) state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (bus.core_done_i)  state_d = EMIT;
                else if (wd_expired)  state_d = DONE;
            end
            EMIT:  if (out_hs && word_last) state_d = blk_last ? DONE : LOAD;
            // An empty job lingers one extra cycle here so its done pulse lands two cycles after start.
            DONE:  if (!hold_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            key_q     <= '0;
            blk_q     <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            n_blk_q   <= '0;
            key_len_q <= 1'b0;
            key_vld_q <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            wd_q      <= '0;
        end else begin
            key_vld_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start_i) begin
                    err_q  <= 1'b0;
                    hold_q <= (n_blocks_i == '0);
                    if (n_blocks_i != '0) begin
                        n_blk_q   <= n_blocks_i;
                        key_len_q <= key_len_i;
                        blk_cnt_q <= '0;
                        idx_q     <= '0;
                        key_q     <= '0;
                    end
                end
                KEY: if (in_hs) begin
                    key_q[3'd7 - idx_q] <= bus.in_data_i;
                    idx_q               <= key_last ? 3'd0 : idx_q + 3'd1;
                    key_vld_q           <= key_last;
                end
                LOAD: if (in_hs) begin
                    blk_q[2'd3 - idx_q[1:0]] <= bus.in_data_i;
                    idx_q                    <= word_last ? 3'd0 : idx_q + 3'd1;
                end
                START: wd_q <= WD_W'(1);
                WAIT: begin
                    if (bus.core_done_i) res_q <= bus.core_result_i;
                    else if (wd_expired) err_q <= 1'b1;
                    else                 wd_q  <= wd_q + 1'b1;
                end
                EMIT: if (out_hs) begin
                    idx_q <= word_last ? 3'd0 : idx_q + 3'd1;
                    if (word_last) blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                end
                DONE: hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef AES_SEQ_CBC_EN
    logic [127:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            chain_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            chain_q <= iv_i;
        end else if (state_q == WAIT && bus.core_done_i) begin
            chain_q <= bus.core_result_i;
        end
    end

    assign bus.core_block_o = blk_q ^ chain_q;
`else
    logic unused_iv;
    assign unused_iv        = ^iv_i;
    assign bus.core_block_o = blk_q;
`endif

    assign bus.in_ready_o       = (state_q == KEY) || (state_q == LOAD);
    assign bus.out_valid_o      = (state_q == EMIT);
    assign bus.out_data_o       = res_q[2'd3 - idx_q[1:0]];
    assign bus.core_key_o       = key_q;
    assign bus.core_key_valid_o = key_vld_q;
    assign bus.core_start_o     = (state_q == START);
    assign busy_o               = (state_q != IDLE);
    assign done_o               = (state_q == DONE) && !hold_q;
    assign err_o                = err_q;
    assign blk_cnt_o            = blk_cnt_q;
    assign state_dbg_o          = state_q;
endmodule

// File: doc/aes_seq_ctrl.md
# aes_seq_ctrl

Block sequencer between the AES streamer's 32-bit word streams and a 128-bit AES round core. For each job it:
- collects the key words and packs them into a core key;
- collects each group of four input words into a 128-bit block and starts the core;
- waits for the core result and re-serialises it onto the output stream;
- counts blocks and signals job completion.

It replaces direct streamer-to-engine wiring and gives the control unit a single start/done interface per job.

## Interface
Parameters:
- CNT_W, 16, width of block counter and `n_blocks_i`
- CORE_LAT_MAX, 64, watchdog bound in cycles for `core_done_i` after `core_start_o`

Ports:
- `clk_i` in 1: sole clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: job start pulse; sampled in IDLE only.
- `clear_i` in 1: synchronous soft clear, same effect as `rst_i`.
- `n_blocks_i` in CNT_W: blocks per job; sampled at accepted `start_i`.
- `key_len_i` in 1: 0 = AES-128 (4 key words), 1 = AES-256 (8 key words); sampled at `start_i`.
- `iv_i` in 128: CBC initial vector; sampled at `start_i`; ignored without CBC.
- `in_data_i` in 32: input word stream data.
- `in_valid_i` in 1: input word valid.
- `in_ready_o` out 1: input word ready.
- `out_data_o` out 32: output word stream data.
- `out_valid_o` out 1: output word valid.
- `out_ready_i` in 1: output word ready.
- `core_key_o` out 256: packed key; for AES-128 the key sits in [255:128], [127:0] = 0.
- `core_key_valid_o` out 1: one-cycle key load pulse.
- `core_block_o` out 128: block to the core.
- `core_start_o` out 1: one-cycle core start pulse.
- `core_done_i` in 1: core result valid pulse.
- `core_result_i` in 128: core result.
- `busy_o` out 1: high in any state except IDLE.
- `done_o` out 1: one-cycle job-complete pulse.
- `err_o` out 1: watchdog expired; sticky until the next `start_i`, `clear_i` or reset.
- `blk_cnt_o` out CNT_W: blocks fully emitted in the current job.

## Operation
- States: IDLE, KEY, LOAD, START, WAIT, EMIT, DONE.
- IDLE:
  - `start_i` with `n_blocks_i` = 0 → DONE.
  - `start_i` with `n_blocks_i` ≠ 0 → KEY; clears `blk_cnt_o`, `err_o` and the word index.
- KEY:
  - `in_ready_o` = 1; each handshake shifts one word in.
  - The first word lands in the MSBs: [255:224] is key word 0.
  - After 4 or 8 words: pulse `core_key_valid_o` on the following cycle, → LOAD.
- LOAD:
  - `in_ready_o` = 1; packs 4 words, word 0 in [127:96].
  - After the 4th word → START.
- START:
  - `core_start_o` = 1 for exactly one cycle, `core_block_o` stable; → WAIT.
- WAIT:
  - `core_done_i` captures `core_result_i` into the output register → EMIT.
  - A watchdog counts from entry. When it reaches CORE_LAT_MAX without `core_done_i`: set `err_o` → DONE.
- EMIT:
  - `out_valid_o` = 1; word 0 = result[127:96].
  - Data holds stable while valid is high and ready is low.
  - After the 4th handshake, `blk_cnt_o` increments. If it equals `n_blocks`, → DONE; else → LOAD.
- DONE:
  - `done_o` = 1 for one cycle → IDLE.
- Ignored events:
  - `start_i` outside IDLE.
  - `core_done_i` outside WAIT.
  - Input words outside KEY/LOAD (`in_ready_o` = 0).
- `clear_i` or `rst_i` in any state: → IDLE next cycle; discards partial words, no `done_o`.
- No overlap: the next block's input is not accepted during EMIT.
- `core_key_o` and `core_block_o` hold their values until overwritten.

## Timing
- Reset values: all outputs 0; state IDLE; all internal registers 0.
- `in_ready_o` and `out_valid_o` are decoded from registered state; no combinational path from `out_ready_i` or `in_valid_i` to any output.
- `start_i` at cycle t → `busy_o` = 1 and `in_ready_o` = 1 at t+1.
- Last key word accepted at cycle k → `core_key_valid_o` at k+1.
- 4th block word accepted at cycle s → `core_start_o` at s+1.
- `core_done_i` at cycle d → first `out_valid_o` at d+1.
- Final output handshake at cycle e → `done_o` at e+1, `busy_o` = 0 at e+2.
- Zero-wait-state throughput per block: 4 + 1 + core latency + 1 + 4 cycles.
- Counter and word index wrap only at reset; `n_blocks_i` = 2^CNT_W−1 is legal.

## Configuration
- Macro `AES_SEQ_CBC_EN`, defined: CBC-encrypt chaining is compiled in.
  - A 128-bit chain register loads `iv_i` at `start_i`.
  - `core_block_o` = packed input ^ chain.
  - The chain register loads `core_result_i` on `core_done_i`.
- Macro undefined: ECB only.
  - `core_block_o` = packed input.
  - `iv_i` is unused and no chain register is built.

## Test plan
- AES-128 single block, stub core returns the block unchanged after 10 cycles. Key 00010203..0c0d0e0f, input words 00112233, 44556677, 8899aabb, ccddeeff:
  - `core_key_o[255:128]` = 000102..0f.
  - Output words are identical in order.
  - `blk_cnt_o` = 1, one `done_o` pulse.
- AES-256, 3 blocks, `out_ready_i` toggling every other cycle:
  - 8 key words are accepted.
  - 12 output words arrive in order and hold stable while stalled.
  - `blk_cnt_o` ends at 3; `done_o` follows the 12th handshake by 1 cycle.
- `n_blocks_i` = 0 with `start_i`:
  - `done_o` 2 cycles after start.
  - No `in_ready_o`, `core_key_valid_o` or `core_start_o`.
- `clear_i` asserted after 2 of 4 block words:
  - IDLE next cycle, no `done_o`.
  - A restarted job with fresh data produces correct output.
- Stub core never returns `core_done_i`:
  - `err_o` = 1 CORE_LAT_MAX cycles after `core_start_o`, then a `done_o` pulse.
  - `err_o` clears at the next `start_i`.
- `AES_SEQ_CBC_EN` defined, iv 0f0f..0f, identity core, 2 blocks of all-zero input:
  - Block 0 output 0f0f..0f.
  - Block 1 output 0f0f..0f (0 ^ previous result).
